dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-master round-robin arbiter for the single-port data memory (combinational read, write at posedge clk).
//  Master 0 is the CPU load/store port; master 1 is the peripheral/DMA port.
//  Owner is registered, bursts are bounded, and misaligned accesses are blocked.
//  Sits between the requesters and the memory's rd/wr/addr/wdata/rdata pins.
// PARAMETERS
//  MAX_BURST  4  max consecutive beats one owner keeps the memory while the other master waits (1..15)
//  CNT_W      4  beat-counter width; MAX_BURST <= 2**CNT_W-1
// PORTS
//  clk        in   1   system clock, all state on posedge
//  reset      in   1   asynchronous, active-high reset
//  req0       in   1   master 0 request; held with wr0/addr0/wdata0 stable until ack0
//  wr0        in   1   master 0: 1=write, 0=read
//  addr0      in   32  master 0 byte address, word aligned
//  wdata0     in   32  master 0 write data
//  ack0       out  1   master 0 beat completes this cycle
//  rdata0     out  32  master 0 read data, valid while ack0 & ~wr0
//  err0       out  1   master 0 misaligned beat (addr0[1:0]!=0) acked with no effect
//  req1..err1      same set for master 1
//  mem_rd     out  1   to memory rd
//  mem_wr     out  1   to memory wr
//  mem_addr   out  32  to memory addr
//  mem_wdata  out  32  to memory wdata
//  mem_rdata  in   32  from memory rdata
//  owner      out  2   00=idle, 01=M0, 10=M1 (registered state)
// BEHAVIOUR
//  State: IDLE/OWN0/OWN1; beat counter cnt[CNT_W-1:0]; last (last master granted).
//  Reset (async): IDLE, cnt=0, last=1 so M0 wins the first tie. All outputs 0 while reset is high,
//   including mem_wr mid-cycle.
//  IDLE: req0&req1 -> OWN of ~last; single req -> that master's OWN; none -> stay. cnt=0 on entry.
//  OWNx, per posedge:
//   - reqx & (~req_other | cnt<MAX_BURST-1): stay, cnt++ (saturating).
//   - else if req_other: go to OWN_other, cnt=0, last=other. No idle bubble.
//   - else (~reqx, ~req_other): go to IDLE.
//  Grant latency: req rising in IDLE in cycle n -> ack in cycle n+1. Parked owner: ack same cycle.
//  ackx = (state==OWNx) & reqx, combinational. One beat per ack cycle.
//   Master may change addr/wdata/wr after each ack for the next beat.
//  Memory drive: mem_addr/mem_wdata muxed from owner; zero when IDLE or owner not requesting.
//   mem_rd = ack & ~wr & aligned.
//   mem_wr = ack & wr & aligned.
//   Write lands at the posedge ending the ack cycle.
//  Misaligned beat: ack=1 and err=1 for that cycle; mem_rd=mem_wr=0; rdata=0.
//  rdatax = mem_rdata when ackx & ~wrx & aligned, else 0. Out-of-range is handled by the memory (returns 0).
//  Fairness: a waiting master is granted within MAX_BURST cycles of the owner's first beat.
//  Owner may drop req without an ack. The arbiter releases the memory on the next edge.
// TESTING
//  1. Reset with req0=1 -> ack0=0, mem_wr=0, owner=00.
//     Release reset -> owner=01 after first edge, ack0=1.
//  2. Sole requester: M0 writes 0xDEADBEEF to 0x10, then reads 0x10 ->
//     ack0 one cycle after req0; rdata0=0xDEADBEEF on the read beat.
//  3. req0=req1=1 from IDLE after reset -> M0 first.
//     Both held: ownership alternates every MAX_BURST=4 beats (4xM0, 4xM1, ...); no gap cycles.
//  4. M1 write to 0x22 -> ack1=1, err1=1, mem_wr=0; a read of 0x20 afterwards is unchanged.
//  5. Async reset pulse mid-cycle while M1 write acked -> mem_wr drops immediately;
//     target word unchanged; state IDLE.
//  6. M0 drops req after 2 beats with M1 idle -> owner=00 next cycle.
//     req1 then raised -> ack1 one cycle later.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port data memory.
// The owner is registered, bursts are capped at MAX_BURST beats, and misaligned beats are acked with an error.
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        wr0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic [31:0] rdata0,
    output logic        err0,
    input  logic        req1,
    input  logic        wr1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_reg;

    logic             cnt_below;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_below = (cnt_reg < BURST_LAST);
    assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

    // The owner keeps the memory while it requests, unless the other master
    // is waiting and the burst budget is spent; a handover never idles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (req0 && (!req1 || last_reg)) begin
                        state_reg <= OWN0;
                        last_reg  <= 1'b0;
                    end else if (req1) begin
                        state_reg <= OWN1;
                        last_reg  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (req0 && (!req1 || cnt_below)) begin
                        cnt_reg <= cnt_inc;
                    end else if (req1) begin
                        state_reg <= OWN1;
                        cnt_reg   <= '0;
                        last_reg  <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end
                end
                OWN1: begin
                    if (req1 && (!req0 || cnt_below)) begin
                        cnt_reg <= cnt_inc;
                    end else if (req0) begin
                        state_reg <= OWN0;
                        cnt_reg   <= '0;
                        last_reg  <= 1'b0;
                    end else begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    logic aligned0;
    logic aligned1;

    assign aligned0 = (addr0[1:0] == 2'b00);
    assign aligned1 = (addr1[1:0] == 2'b00);

    // Every output derives from the state, so an asynchronous reset silences the memory pins at once.
    assign ack0 = (state_reg == OWN0) && req0;
    assign ack1 = (state_reg == OWN1) && req1;
    assign err0 = ack0 && !aligned0;
    assign err1 = ack1 && !aligned1;

    assign mem_addr  = ack0 ? addr0  : (ack1 ? addr1  : 32'h0);
    assign mem_wdata = ack0 ? wdata0 : (ack1 ? wdata1 : 32'h0);
    assign mem_rd    = (ack0 && !wr0 && aligned0) || (ack1 && !wr1 && aligned1);
    assign mem_wr    = (ack0 && wr0 && aligned0) || (ack1 && wr1 && aligned1);

    assign rdata0 = (ack0 && !wr0 && aligned0) ? mem_rdata : 32'h0;
    assign rdata1 = (ack1 && !wr1 && aligned1) ? mem_rdata : 32'h0;

    assign owner = state_reg;

endmodule
